// File: rtl/fp_pkg.sv
// Shared constants for the 255-bit modular add/sub issue path: width, modulus q,
// default tag width, and the modular negation used to turn a-b into a+(q-b).
package fp_pkg;

  localparam int FP_W     = 255;
  localparam int FP_TAG_W = 4;

  localparam logic [FP_W-1:0] FP_Q =
    255'd2261564242916331941866620800950935700259179388000792266395655937654553313279;

  // Canonical b only: 0 maps to 0 so the core never sees the non-canonical q.
  function automatic logic [FP_W-1:0] fp_neg(input logic [FP_W-1:0] b);
    return (b == '0) ? '0 : FP_Q - b;
  endfunction

endpackage

// File: rtl/fp_result_fifo.sv
// Sync FIFO with a registered head word: rdata_o/valid_o come straight from flops.
// Simultaneous push and pop is legal at any fill level, including full.
module fp_result_fifo #(
  parameter int DW    = 259,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          rd_i,
  output logic [DW-1:0] rdata_o,
  output logic          valid_o,
  output logic [CW-1:0] cnt_o
);

  logic [DEPTH-1:0][DW-1:0] mem_q;
  logic [AW-1:0]            wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [DW-1:0]            head_q;
  logic                     vld_q, pop;

  assign pop    = rd_i && vld_q;
  assign rd_nxt = rd_ptr_q + AW'(1);

  always_comb begin
    cnt_d = cnt_q;
    if (wr_i && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!wr_i && pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
      vld_q    <= 1'b0;
    end else begin
      if (wr_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_nxt;
      cnt_q <= cnt_d;
      vld_q <= (cnt_d != '0);
      // Head reloads from the incoming word when the queue is (about to be) empty,
      // otherwise from the next stored entry.
      if (wr_i && (!vld_q || (pop && cnt_q == CW'(1))))
        head_q <= wdata_i;
      else if (pop && cnt_q > CW'(1))
        head_q <= mem_q[rd_nxt];
    end
  end

  assign rdata_o = head_q;
  assign valid_o = vld_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/fp_addsub_issue.sv
// Issue/collect stage around the fixed-latency modular adder core fp_add.
// Optional FP_ADDSUB_RANGE_CHECK_EN adds sticky err/err_tag for non-canonical operands.
module fp_addsub_issue
  import fp_pkg::*;
#(
  parameter int W           = FP_W,
  parameter int ADD_LATENCY = 5,
  parameter int DEPTH       = 8,
  parameter int TAG_W       = FP_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [W-1:0]     add_a,
  output logic [W-1:0]     add_b,
  input  logic [W-1:0]     add_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_d,
  output logic [TAG_W-1:0] out_tag,
`ifdef FP_ADDSUB_RANGE_CHECK_EN
  output logic             err,
  output logic [TAG_W-1:0] err_tag,
`endif
  output logic             busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic                             accept, fifo_wr, run_q;
  logic [CW-1:0]                    inflight_q, inflight_d, fifo_cnt;
  logic [CW:0]                      credit_used;
  logic [ADD_LATENCY:0]             vld_pipe_q;
  logic [ADD_LATENCY:0][TAG_W-1:0]  tag_pipe_q;
  logic [W-1:0]                     add_a_q, add_b_q, add_b_d;

  // Every accepted op holds a FIFO slot from accept until it is read out.
  assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_cnt};
  assign in_ready    = run_q && (credit_used < (CW+1)'(DEPTH));
  assign accept      = in_valid && in_ready;
  assign fifo_wr     = vld_pipe_q[ADD_LATENCY];
  assign add_b_d     = in_op ? W'(fp_neg(FP_W'(in_b))) : in_b;

  always_comb begin
    inflight_d = inflight_q;
    case ({accept, fifo_wr})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q      <= 1'b0;
      vld_pipe_q <= '0;
      tag_pipe_q <= '0;
      add_a_q    <= '0;
      add_b_q    <= '0;
      inflight_q <= '0;
    end else begin
      run_q      <= 1'b1;
      vld_pipe_q <= {vld_pipe_q[ADD_LATENCY-1:0], accept};
      tag_pipe_q <= {tag_pipe_q[ADD_LATENCY-1:0], in_tag};
      add_a_q    <= accept ? in_a    : '0;
      add_b_q    <= accept ? add_b_d : '0;
      inflight_q <= inflight_d;
    end
  end

  fp_result_fifo #(
    .DW    (W + TAG_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_i    (fifo_wr),
    .wdata_i ({add_d, tag_pipe_q[ADD_LATENCY]}),
    .rd_i    (out_ready),
    .rdata_o ({out_d, out_tag}),
    .valid_o (out_valid),
    .cnt_o   (fifo_cnt)
  );

  assign add_a = add_a_q;
  assign add_b = add_b_q;
  assign busy  = (inflight_q != '0) || (fifo_cnt != '0);

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst && fifo_wr)
      assert (fifo_cnt != CW'(DEPTH)) else $error("fp_addsub_issue: result FIFO overflow");
  end
`endif

`ifdef FP_ADDSUB_RANGE_CHECK_EN
  logic             err_q;
  logic [TAG_W-1:0] err_tag_q;
  logic             bad_op;

  assign bad_op = (in_a >= W'(FP_Q)) || (in_b >= W'(FP_Q));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q     <= 1'b0;
      err_tag_q <= '0;
    end else if (accept && bad_op) begin
      err_q <= 1'b1;
      if (!err_q) err_tag_q <= in_tag;
    end
  end

  assign err     = err_q;
  assign err_tag = err_tag_q;
`endif

endmodule
